// File: rtl/mem_model_resp_fifo.sv
// -----------------------------------------------------------------------------
// mem_model_resp_fifo
// Response queue for the L1 memory model. It is a circular buffer with a
// registered occupancy count and supports a push and a pop in the same cycle,
// including when it is full or holds exactly one entry. The head entry is
// presented combinationally and forced to zero while the queue is empty, so
// the data outputs read as zero straight out of reset.
//
// Ports
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset (clears pointers and count)
//   push_i   in   write data_i into the tail
//   data_i   in   WIDTH-bit entry to push
//   pop_i    in   remove the head entry (ignored while empty)
//   valid_o  out  queue is non-empty
//   data_o   out  head entry (zero while empty)
//   count_o  out  current number of stored entries
// -----------------------------------------------------------------------------
module mem_model_resp_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign valid_o = (count != '0);
    assign do_pop  = pop_i && valid_o;
    // A push into a full queue is legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);

    assign data_o  = valid_o ? storage[rd_ptr] : '0;
    assign count_o = count;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            storage[wr_ptr] <= data_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_l1_mem_model_pipe.sv
// -----------------------------------------------------------------------------
// cpu_l1_mem_model_pipe
// Behavioural-but-synthesizable L1 memory model with a req/gnt request side
// and a valid/ready response side. Reads sample the array in the accept
// cycle, travel through a fixed-latency pipeline and land in a response
// queue; writes update the array with byte enables and produce no response.
// Read grants are throttled so that every accepted read is guaranteed a queue
// slot, and an optional periodic stall exercises requester back-pressure.
//
// Ports
//   clk_i     in   clock
//   rst_ni    in   asynchronous active-low reset (also clears the array)
//   req_i     in   request valid
//   we_i      in   1 = write, 0 = read
//   be_i      in   byte enables for writes
//   addr_i    in   byte address
//   wdata_i   in   write data
//   gnt_o     out  request accepted this cycle (combinational)
//   rvalid_o  out  read response available
//   rready_i  in   read response consumed
//   rdata_o   out  read data (zero for out-of-range reads)
//   rerr_o    out  read address was outside the array
// -----------------------------------------------------------------------------
module cpu_l1_mem_model_pipe #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int DEPTH       = 16384,
    parameter int RD_LAT      = 1,
    parameter int RESP_DEPTH  = 4,
    parameter int STALL_EVERY = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                gnt_o,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rerr_o
);

    localparam int BE_W   = DATA_W / 8;
    localparam int OFFS_W = $clog2(BE_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int FCNT_W = $clog2(RESP_DEPTH + 1);
    localparam int OCNT_W = $clog2(RESP_DEPTH + RD_LAT + 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              stall;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] rd_data_now;
    logic              rd_err_now;

    logic              push_v;
    logic [DATA_W-1:0] push_d;
    logic              push_e;
    logic [OCNT_W-1:0] inflight;
    logic [FCNT_W-1:0] fifo_cnt;
    logic [DATA_W:0]   head;

    assign word_idx    = addr_i >> OFFS_W;
    assign in_range    = (word_idx < ADDR_W'(DEPTH));
    assign idx         = word_idx[IDX_W-1:0];

    assign rd_acc      = gnt_o && !we_i;
    assign wr_acc      = gnt_o && we_i && in_range;
    assign rd_data_now = in_range ? mem[idx] : '0;
    assign rd_err_now  = !in_range;

    // Periodic grant stall: the counter advances on every requesting cycle,
    // whether or not that cycle is granted, and the last count of each period
    // is the stalled one.
    if (STALL_EVERY > 0) begin : g_stall
        localparam int SC_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
        logic [SC_W-1:0] stall_cnt;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stall_cnt <= '0;
            end else if (req_i) begin
                if (stall_cnt == SC_W'(STALL_EVERY - 1)) begin
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end

        assign stall = (stall_cnt == SC_W'(STALL_EVERY - 1));
    end else begin : g_no_stall
        assign stall = 1'b0;
    end

    // The accept-cycle array sample counts as the first latency stage, so
    // RD_LAT-1 registers follow it and the last one feeds the queue. With
    // RD_LAT=1 the sample is written into the queue at the accept edge.
    if (RD_LAT == 1) begin : g_lat1
        assign push_v   = rd_acc;
        assign push_d   = rd_data_now;
        assign push_e   = rd_err_now;
        assign inflight = '0;
    end else begin : g_latn
        localparam int NS = RD_LAT - 1;
        logic [NS-1:0]     pipe_v;
        logic [NS-1:0]     pipe_e;
        logic [DATA_W-1:0] pipe_d [NS];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pipe_v <= '0;
            end else begin
                pipe_v[0] <= rd_acc;
                for (int s = 1; s < NS; s++) begin
                    pipe_v[s] <= pipe_v[s-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            pipe_d[0] <= rd_data_now;
            pipe_e[0] <= rd_err_now;
            for (int s = 1; s < NS; s++) begin
                pipe_d[s] <= pipe_d[s-1];
                pipe_e[s] <= pipe_e[s-1];
            end
        end

        always_comb begin
            inflight = '0;
            for (int s = 0; s < NS; s++) begin
                inflight = inflight + OCNT_W'(pipe_v[s]);
            end
        end

        assign push_v = pipe_v[NS-1];
        assign push_d = pipe_d[NS-1];
        assign push_e = pipe_e[NS-1];
    end

    // A read is granted only when it is certain to find a queue slot: every
    // earlier read is either still in the pipeline or sitting in the queue.
    // Credit freed by a pop becomes usable from the following cycle.
    always_comb begin
        gnt_o = 1'b0;
        if (req_i && !stall) begin
            if (we_i) begin
                gnt_o = 1'b1;
            end else if ((inflight + OCNT_W'(fifo_cnt)) < OCNT_W'(RESP_DEPTH)) begin
                gnt_o = 1'b1;
            end
        end
    end

    // The whole array is cleared by reset; writes honour byte enables and
    // are visible to any read accepted from the next cycle on.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    mem_model_resp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RESP_DEPTH),
        .CNT_W (FCNT_W)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_v),
        .data_i  ({push_e, push_d}),
        .pop_i   (rready_i),
        .valid_o (rvalid_o),
        .data_o  (head),
        .count_o (fifo_cnt)
    );

    assign rdata_o = head[DATA_W-1:0];
    assign rerr_o  = head[DATA_W];

endmodule
